// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared types and constants for the GPR write-back arbiter.
// Holds the source encodings, the starve counter width and a saturating increment.
package gpr_wb_arbiter_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG     = 32;
  localparam int CNT_W    = 4;

  localparam logic [CNT_W-1:0] STARVE_SAT = 4'd15;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LSU  = 2'd1,
    WB_MDU  = 2'd2,
    WB_NONE = 2'd3
  } wb_src_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == STARVE_SAT) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/gpr_wb_arbiter_rr.sv
// LSU/MDU round-robin with a starvation counter.
// The winner is a pure function of the valids and ptr; override asks the top to pre-empt the ALU.
module gpr_wb_arbiter_rr
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    lsu_valid_i,
  input  logic    mdu_valid_i,
  input  logic    grant_i,
  output wb_src_e winner_o,
  output logic    override_o
);

  localparam logic [CNT_W-1:0] STARVE_TH = CNT_W'(STARVE_MAX);

  wb_src_e          ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    winner_o = WB_NONE;
    if (lsu_valid_i && mdu_valid_i) winner_o = ptr_q;
    else if (lsu_valid_i)           winner_o = WB_LSU;
    else if (mdu_valid_i)           winner_o = WB_MDU;
  end

  assign override_o = (winner_o != WB_NONE) && (cnt_q >= STARVE_TH);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (grant_i) begin
      ptr_d = (winner_o == WB_LSU) ? WB_MDU : WB_LSU;
      cnt_d = '0;
    end else if (lsu_valid_i || mdu_valid_i) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= WB_LSU;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR write-back arbiter: picks one of ALU/LSU/MDU per cycle, registers the write port
// and maintains the pending-write scoreboard used by issue for hazard stalls.
module gpr_wb_arbiter
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [4:0]        alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [4:0]        lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [4:0]        mdu_rd,
  input  logic [XLEN-1:0]   mdu_data,
  input  logic              iss_valid,
  input  logic [4:0]        iss_rd,
  output logic [NREG-1:0]   busy,
  output logic [4:0]        rd,
  output logic              rd_w_en,
  output logic              rd_idx_0,
  output logic [XLEN-1:0]   x_rd
);

  wb_src_e rr_win;
  logic    rr_ovr;
  logic    rr_grant;
  wb_src_e sel;
  logic    xfer;

  logic [4:0]      src_rd;
  logic [XLEN-1:0] src_data;

  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] x_rd_q, x_rd_d;
  logic            rd_idx_0_q, rd_idx_0_d;
  logic            rd_w_en_q, rd_w_en_d;
  logic [NREG-1:1] busy_q, busy_d;

  gpr_wb_arbiter_rr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_rr (
    .clk         (clk),
    .rst         (rst),
    .lsu_valid_i (lsu_valid),
    .mdu_valid_i (mdu_valid),
    .grant_i     (rr_grant),
    .winner_o    (rr_win),
    .override_o  (rr_ovr)
  );

  // ALU wins unless the LSU/MDU side has waited too long; nothing is granted in reset.
  always_comb begin
    sel = WB_NONE;
    if (!rst) begin
      if (alu_valid && !rr_ovr) sel = WB_ALU;
      else                      sel = rr_win;
    end
  end

  assign alu_ready = (sel == WB_ALU);
  assign lsu_ready = (sel == WB_LSU);
  assign mdu_ready = (sel == WB_MDU);
  assign rr_grant  = lsu_ready || mdu_ready;
  assign xfer      = (sel != WB_NONE);

  always_comb begin
    src_rd   = alu_rd;
    src_data = alu_data;
    case (sel)
      WB_LSU: begin
        src_rd   = lsu_rd;
        src_data = lsu_data;
      end
      WB_MDU: begin
        src_rd   = mdu_rd;
        src_data = mdu_data;
      end
      default: begin
        src_rd   = alu_rd;
        src_data = alu_data;
      end
    endcase
  end

  always_comb begin
    rd_d       = rd_q;
    x_rd_d     = x_rd_q;
    rd_idx_0_d = rd_idx_0_q;
    rd_w_en_d  = 1'b0;
    if (xfer) begin
      rd_d       = src_rd;
      x_rd_d     = src_data;
      rd_idx_0_d = (src_rd == 5'd0);
      rd_w_en_d  = (src_rd != 5'd0);
    end
  end

  // Clear on the write edge, then set: a fresh issue to the same index must stay pending.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (xfer && (src_rd == 5'(i)))       busy_d[i] = 1'b0;
      if (iss_valid && (iss_rd == 5'(i)))  busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q       <= '0;
      x_rd_q     <= '0;
      rd_idx_0_q <= 1'b1;
      rd_w_en_q  <= 1'b0;
      busy_q     <= '0;
    end else begin
      rd_q       <= rd_d;
      x_rd_q     <= x_rd_d;
      rd_idx_0_q <= rd_idx_0_d;
      rd_w_en_q  <= rd_w_en_d;
      busy_q     <= busy_d;
    end
  end

  assign rd       = rd_q;
  assign x_rd     = x_rd_q;
  assign rd_idx_0 = rd_idx_0_q;
  assign rd_w_en  = rd_w_en_q;
  assign busy     = {busy_q, 1'b0};

  a_ready_onehot: assert property (@(posedge clk) $onehot0({alu_ready, lsu_ready, mdu_ready}));
  a_ready_valid:  assert property (@(posedge clk)
    (!alu_ready || alu_valid) && (!lsu_ready || lsu_valid) && (!mdu_ready || mdu_valid));

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: reset, single write, arbitration with starvation,
// x0 writes, scoreboard set/clear and reset in the middle of traffic.
module tb_gpr_wb_arbiter;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid, lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            mdu_valid, mdu_ready;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_data;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [31:0]     busy;
  logic [4:0]      rd;
  logic            rd_w_en;
  logic            rd_idx_0;
  logic [XLEN-1:0] x_rd;

  int n_chk = 0;
  int n_err = 0;

  gpr_wb_arbiter #(
    .XLEN       (XLEN),
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_rd    (mdu_rd),
    .mdu_data  (mdu_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .busy      (busy),
    .rd        (rd),
    .rd_w_en   (rd_w_en),
    .rd_idx_0  (rd_idx_0),
    .x_rd      (x_rd)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    mdu_valid = 1'b0;
    iss_valid = 1'b0;
  endtask

  // Check readies {mdu,lsu,alu} after inputs settle, then advance past the edge.
  task automatic step(input string tag, input logic [2:0] exp_rdy);
    #1;
    check_eq({tag, ".rdy"}, {61'd0, mdu_ready, lsu_ready, alu_ready}, {61'd0, exp_rdy});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] e_rd, input logic [63:0] e_x,
                         input logic e_en, input logic e_z, input logic [31:0] e_busy);
    check_eq({tag, ".rd"},   64'(rd),       64'(e_rd));
    check_eq({tag, ".x_rd"}, x_rd,          e_x);
    check_eq({tag, ".wen"},  64'(rd_w_en),  64'(e_en));
    check_eq({tag, ".z"},    64'(rd_idx_0), 64'(e_z));
    check_eq({tag, ".busy"}, 64'(busy),     64'(e_busy));
  endtask

  logic [2:0] seq_a [10];
  logic [2:0] seq_b [5];

  initial begin
    seq_a = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010,
              3'b001, 3'b001, 3'b001, 3'b001, 3'b100};
    seq_b = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010};

    // Reset with every source and issue active
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'hAAAA;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 64'hBBBB;
    mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 64'hCCCC;
    iss_valid = 1'b1; iss_rd = 5'd3;
    step("rst0", 3'b000);
    chk_out("rst0", 5'd0, 64'h0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    step("rst1", 3'b000);
    chk_out("rst1", 5'd0, 64'h0, 1'b0, 1'b1, 32'h0);

    // Single ALU write
    @(negedge clk);
    rst = 1'b0; idle();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    step("alu1", 3'b001);
    chk_out("alu1", 5'd5, 64'h1234, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    idle();
    step("alu_idle", 3'b000);
    chk_out("alu_idle", 5'd5, 64'h1234, 1'b0, 1'b0, 32'h0);

    // Three-way conflict: A A A A L A A A A M
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'hA1;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 64'hB2;
    mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 64'hC3;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      step($sformatf("conf%0d", k), seq_a[k]);
      check_eq($sformatf("conf%0d.rd", k), 64'(rd),
               (seq_a[k] == 3'b001) ? 64'd1 : (seq_a[k] == 3'b010) ? 64'd2 : 64'd3);
      check_eq($sformatf("conf%0d.wen", k), 64'(rd_w_en), 64'd1);
    end

    // Write to x0 is accepted but not enabled
    @(negedge clk);
    idle();
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'hFFFF;
    step("x0", 3'b010);
    chk_out("x0", 5'd0, 64'hFFFF, 1'b0, 1'b1, 32'h0);

    // Scoreboard: issue 7, write it back three cycles later
    @(negedge clk);
    idle();
    iss_valid = 1'b1; iss_rd = 5'd7;
    step("iss7", 3'b000);
    chk_out("iss7", 5'd0, 64'hFFFF, 1'b0, 1'b1, 32'h80);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      idle();
      step($sformatf("wait%0d", k), 3'b000);
      check_eq($sformatf("wait%0d.busy", k), 64'(busy), 64'h80);
    end
    @(negedge clk);
    idle();
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 64'h77;
    step("mdu7", 3'b100);
    chk_out("mdu7", 5'd7, 64'h77, 1'b1, 1'b0, 32'h0);

    // Same-edge issue and write of 7: set wins
    @(negedge clk);
    idle();
    iss_valid = 1'b1; iss_rd = 5'd7;
    step("iss7b", 3'b000);
    chk_out("iss7b", 5'd7, 64'h77, 1'b0, 1'b0, 32'h80);
    @(negedge clk);
    idle();
    iss_valid = 1'b1; iss_rd = 5'd7;
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 64'h78;
    step("same7", 3'b100);
    chk_out("same7", 5'd7, 64'h78, 1'b1, 1'b0, 32'h80);

    // Issue 9 while 7 drains through the ALU; then an issue to x0 changes nothing
    @(negedge clk);
    idle();
    iss_valid = 1'b1; iss_rd = 5'd9;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h79;
    step("iss9", 3'b001);
    chk_out("iss9", 5'd7, 64'h79, 1'b1, 1'b0, 32'h200);
    @(negedge clk);
    idle();
    iss_valid = 1'b1; iss_rd = 5'd0;
    step("iss0", 3'b000);
    chk_out("iss0", 5'd7, 64'h79, 1'b0, 1'b0, 32'h200);

    // Mid-op reset: move ptr to MDU and build up starve count first
    @(negedge clk);
    idle();
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 64'h66;
    step("pre_l", 3'b010);
    chk_out("pre_l", 5'd6, 64'h66, 1'b1, 1'b0, 32'h200);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'h44;
      lsu_valid = 1'b1; lsu_rd = 5'd6;
      step($sformatf("blk%0d", k), 3'b001);
      check_eq($sformatf("blk%0d.rd", k), 64'(rd), 64'd4);
    end
    @(negedge clk);
    rst = 1'b1;
    mdu_valid = 1'b1; mdu_rd = 5'd8; mdu_data = 64'h88;
    step("rst_mid", 3'b000);
    chk_out("rst_mid", 5'd0, 64'h0, 1'b0, 1'b1, 32'h0);

    // After reset: starve count and ptr restart, so ALU x4 then LSU
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      step($sformatf("post%0d", k), seq_b[k]);
      check_eq($sformatf("post%0d.rd", k), 64'(rd), (seq_b[k] == 3'b001) ? 64'd4 : 64'd6);
    end

    @(negedge clk);
    idle();
    step("end", 3'b000);
    check_eq("end.wen", 64'(rd_w_en), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
